axi4_mem_slave: RTL and testbench

// - AXI4 slave responder backed by on-chip dual-port RAM; the far end of the VDMA port's AXI4 master.
// - Accepts INCR write bursts (AW/W/B) and read bursts (AR/R) on independent channels; one outstanding burst per direction.
// - Used as the frame-store model in VDMA benches and as a small on-chip frame buffer in synthesis.

---
 rtl/axi_slv_pkg.sv | 18 +
 rtl/axi4_mem_slave_if.sv | 69 ++++++
 rtl/axi_slv_dpram.sv | 30 +++
 rtl/axi4_mem_slave.sv | 199 +++++++++++++++++++
 tb/tb_axi4_mem_slave.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_slv_pkg.sv
// Shared types and constants for the AXI4 memory slave.
package axi_slv_pkg;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_SEED   = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/axi4_mem_slave_if.sv
// AXI4 bus bundle between a master and the memory slave.
interface axi4_mem_slave_if #(
  parameter int unsigned ASIZE          = 29,
  parameter int unsigned AXI_DSIZE      = 256,
  parameter int unsigned IDSIZE         = 1,
  parameter int unsigned BURST_LEN_SIZE = 8
);
  logic [IDSIZE-1:0]         axi_awid;
  logic [ASIZE-1:0]          axi_awaddr;
  logic [BURST_LEN_SIZE-1:0] axi_awlen;
  logic [2:0]                axi_awsize;
  logic [1:0]                axi_awburst;
  logic                      axi_awlock;
  logic [3:0]                axi_awcache;
  logic [2:0]                axi_awprot;
  logic [3:0]                axi_awqos;
  logic                      axi_awvalid;
  logic                      axi_awready;

  logic [AXI_DSIZE-1:0]      axi_wdata;
  logic [AXI_DSIZE/8-1:0]    axi_wstrb;
  logic                      axi_wlast;
  logic                      axi_wvalid;
  logic                      axi_wready;

  logic [IDSIZE-1:0]         axi_bid;
  logic [1:0]                axi_bresp;
  logic                      axi_bvalid;
  logic                      axi_bready;

  logic [IDSIZE-1:0]         axi_arid;
  logic [ASIZE-1:0]          axi_araddr;
  logic [BURST_LEN_SIZE-1:0] axi_arlen;
  logic [2:0]                axi_arsize;
  logic [1:0]                axi_arburst;
  logic                      axi_arlock;
  logic [3:0]                axi_arcache;
  logic [2:0]                axi_arprot;
  logic [3:0]                axi_arqos;
  logic                      axi_arvalid;
  logic                      axi_arready;

  logic [IDSIZE-1:0]         axi_rid;
  logic [AXI_DSIZE-1:0]      axi_rdata;
  logic [1:0]                axi_rresp;
  logic                      axi_rlast;
  logic                      axi_rvalid;
  logic                      axi_rready;

  modport slave (
    input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awlock,
           axi_awcache, axi_awprot, axi_awqos, axi_awvalid,
           axi_wdata, axi_wstrb, axi_wlast, axi_wvalid, axi_bready,
           axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arlock,
           axi_arcache, axi_arprot, axi_arqos, axi_arvalid, axi_rready,
    output axi_awready, axi_wready, axi_bid, axi_bresp, axi_bvalid,
           axi_arready, axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid
  );

  modport master (
    output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awlock,
           axi_awcache, axi_awprot, axi_awqos, axi_awvalid,
           axi_wdata, axi_wstrb, axi_wlast, axi_wvalid, axi_bready,
           axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arlock,
           axi_arcache, axi_arprot, axi_arqos, axi_arvalid, axi_rready,
    input  axi_awready, axi_wready, axi_bid, axi_bresp, axi_bvalid,
           axi_arready, axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid
  );
endinterface

// File: rtl/axi_slv_dpram.sv
// Simple dual-port RAM: byte-enabled write port, registered read-first read port.
module axi_slv_dpram #(
  parameter int unsigned DW    = 256,
  parameter int unsigned WORDS = 4096,
  parameter int unsigned AW    = $clog2(WORDS)
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [DW/8-1:0] wbe_i,
  input  logic            re_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [DW-1:0]   rdata_o
);
  logic [DW-1:0] mem_q [WORDS];
  logic [DW-1:0] rdata_q;

  // read samples the array before this edge's write lands, so a collision returns old data
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
    if (we_i) begin
      for (int unsigned b = 0; b < DW/8; b++) begin
        if (wbe_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/axi4_mem_slave.sv
// AXI4 slave backed by on-chip RAM; independent write (AW/W/B) and read (AR/R) burst engines.
// Optional macro AXI_SLV_RAND_STALL_EN adds LFSR-driven backpressure on awready/wready/arready/R issue.
module axi4_mem_slave
  import axi_slv_pkg::*;
#(
  parameter int unsigned ASIZE          = 29,
  parameter int unsigned AXI_DSIZE      = 256,
  parameter int unsigned IDSIZE         = 1,
  parameter int unsigned BURST_LEN_SIZE = 8,
  parameter int unsigned MEM_WORDS      = 4096
) (
  input  logic              axi_aclk,
  input  logic              axi_areset,
  axi4_mem_slave_if.slave   s_axi
);
  localparam int unsigned IW   = $clog2(MEM_WORDS);
  localparam int unsigned BOFF = $clog2(AXI_DSIZE/8);

  logic alive_q;
  logic go;

  // readies stay low through reset and rise the cycle after it is released
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) alive_q <= 1'b0;
    else            alive_q <= 1'b1;
  end

`ifdef AXI_SLV_RAND_STALL_EN
  logic [15:0] lfsr_q;

  // free-running backpressure pattern
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) lfsr_q <= LFSR_SEED;
    else            lfsr_q <= lfsr_next(lfsr_q);
  end
  assign go = lfsr_q[0];
`else
  assign go = 1'b1;
`endif

  // ---------------- write side ----------------
  wr_state_t                 wst_q, wst_d;
  logic [IDSIZE-1:0]         wid_q, wid_d;
  logic [IW-1:0]             widx_q, widx_d;
  logic [BURST_LEN_SIZE-1:0] wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [1:0]                bresp_q, bresp_d;
  logic                      awready_w, wready_w, bvalid_w, mem_we;

  // write FSM: address capture, beat acceptance, response
  always_comb begin
    wst_d = wst_q; wid_d = wid_q; widx_d = widx_q;
    wlen_d = wlen_q; wcnt_d = wcnt_q; bresp_d = bresp_q;
    awready_w = 1'b0; wready_w = 1'b0; bvalid_w = 1'b0; mem_we = 1'b0;
    case (wst_q)
      W_IDLE: begin
        awready_w = alive_q && go;
        if (awready_w && s_axi.axi_awvalid) begin
          wid_d  = s_axi.axi_awid;
          widx_d = s_axi.axi_awaddr[BOFF +: IW];
          wlen_d = s_axi.axi_awlen;
          wcnt_d = '0;
          wst_d  = W_DATA;
        end
      end
      W_DATA: begin
        wready_w = go;
        if (wready_w && s_axi.axi_wvalid) begin
          mem_we = !axi_areset;
          widx_d = widx_q + IW'(1);
          wcnt_d = wcnt_q + BURST_LEN_SIZE'(1);
          if (s_axi.axi_wlast || (wcnt_q == wlen_q)) begin
            bresp_d = (s_axi.axi_wlast && (wcnt_q == wlen_q)) ? RESP_OKAY : RESP_SLVERR;
            wst_d   = W_RESP;
          end
        end
      end
      W_RESP: begin
        bvalid_w = 1'b1;
        if (s_axi.axi_bready) wst_d = W_IDLE;
      end
      default: wst_d = W_IDLE;
    endcase
  end

  // write state registers
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      wst_q <= W_IDLE; wid_q <= '0; widx_q <= '0;
      wlen_q <= '0; wcnt_q <= '0; bresp_q <= RESP_OKAY;
    end else begin
      wst_q <= wst_d; wid_q <= wid_d; widx_q <= widx_d;
      wlen_q <= wlen_d; wcnt_q <= wcnt_d; bresp_q <= bresp_d;
    end
  end

  // ---------------- read side ----------------
  rd_state_t                 rdst_q, rdst_d;
  logic [IDSIZE-1:0]         rid_q, rid_d;
  logic [IW-1:0]             ridx_q, ridx_d;
  logic [BURST_LEN_SIZE-1:0] rlen_q, rlen_d, icnt_q, icnt_d;
  logic                      idone_q, idone_d, pipe_q, pipe_d, pipe_last_q, pipe_last_d;
  logic [1:0]                fcnt_q, fcnt_d, nfill;
  logic [AXI_DSIZE-1:0]      f0_data_q, f0_data_d, f1_data_q, f1_data_d, mem_rdata;
  logic                      f0_last_q, f0_last_d, f1_last_q, f1_last_d;
  logic                      arready_w, mem_re, pop, issue;

  // read FSM plus skid: a RAM read is issued only when the skid is sure to have room for it
  always_comb begin
    rdst_d = rdst_q; rid_d = rid_q; ridx_d = ridx_q; rlen_d = rlen_q;
    icnt_d = icnt_q; idone_d = idone_q; pipe_d = 1'b0; pipe_last_d = pipe_last_q;
    f0_data_d = f0_data_q; f0_last_d = f0_last_q;
    f1_data_d = f1_data_q; f1_last_d = f1_last_q;
    arready_w = 1'b0; mem_re = 1'b0; issue = 1'b0;
    pop = (fcnt_q != 2'd0) && s_axi.axi_rready;
    case (rdst_q)
      R_IDLE: begin
        arready_w = alive_q && go;
        if (arready_w && s_axi.axi_arvalid) begin
          rid_d   = s_axi.axi_arid;
          ridx_d  = s_axi.axi_araddr[BOFF +: IW];
          rlen_d  = s_axi.axi_arlen;
          icnt_d  = '0;
          idone_d = 1'b0;
          rdst_d  = R_DATA;
        end
      end
      R_DATA: begin
        issue = !idone_q && go &&
                (({1'b0, fcnt_q} + {2'b00, pipe_q}) <= ({2'b00, pop} + 3'd1));
        if (issue) begin
          mem_re      = 1'b1;
          pipe_d      = 1'b1;
          pipe_last_d = (icnt_q == rlen_q);
          idone_d     = (icnt_q == rlen_q);
          ridx_d      = ridx_q + IW'(1);
          icnt_d      = icnt_q + BURST_LEN_SIZE'(1);
        end
        if (pop && f0_last_q) rdst_d = R_IDLE;
      end
      default: rdst_d = R_IDLE;
    endcase
    // pop shifts entry 1 forward; the beat leaving the RAM lands in the first free slot
    nfill = fcnt_q - {1'b0, pop};
    if (pop) begin
      f0_data_d = f1_data_q; f0_last_d = f1_last_q;
    end
    if (pipe_q) begin
      if (nfill == 2'd0) begin
        f0_data_d = mem_rdata; f0_last_d = pipe_last_q;
      end else begin
        f1_data_d = mem_rdata; f1_last_d = pipe_last_q;
      end
    end
    fcnt_d = nfill + {1'b0, pipe_q};
  end

  // read state registers; skid data needs no reset since fcnt_q qualifies it
  always_ff @(posedge axi_aclk) begin
    f0_data_q <= f0_data_d; f1_data_q <= f1_data_d;
    if (axi_areset) begin
      rdst_q <= R_IDLE; rid_q <= '0; ridx_q <= '0; rlen_q <= '0; icnt_q <= '0;
      idone_q <= 1'b0; pipe_q <= 1'b0; pipe_last_q <= 1'b0; fcnt_q <= '0;
      f0_last_q <= 1'b0; f1_last_q <= 1'b0;
    end else begin
      rdst_q <= rdst_d; rid_q <= rid_d; ridx_q <= ridx_d; rlen_q <= rlen_d; icnt_q <= icnt_d;
      idone_q <= idone_d; pipe_q <= pipe_d; pipe_last_q <= pipe_last_d; fcnt_q <= fcnt_d;
      f0_last_q <= f0_last_d; f1_last_q <= f1_last_d;
    end
  end

  axi_slv_dpram #(.DW(AXI_DSIZE), .WORDS(MEM_WORDS), .AW(IW)) u_ram (
    .clk_i   (axi_aclk),
    .we_i    (mem_we),
    .waddr_i (widx_q),
    .wdata_i (s_axi.axi_wdata),
    .wbe_i   (s_axi.axi_wstrb),
    .re_i    (mem_re),
    .raddr_i (ridx_q),
    .rdata_o (mem_rdata)
  );

  assign s_axi.axi_awready = awready_w;
  assign s_axi.axi_wready  = wready_w;
  assign s_axi.axi_bvalid  = bvalid_w;
  assign s_axi.axi_bid     = wid_q;
  assign s_axi.axi_bresp   = bresp_q;
  assign s_axi.axi_arready = arready_w;
  assign s_axi.axi_rvalid  = (fcnt_q != 2'd0);
  assign s_axi.axi_rdata   = f0_data_q;
  assign s_axi.axi_rlast   = (fcnt_q != 2'd0) && f0_last_q;
  assign s_axi.axi_rid     = rid_q;
  assign s_axi.axi_rresp   = RESP_OKAY;

  logic unused_ok;
  assign unused_ok = ^{s_axi.axi_awaddr, s_axi.axi_awsize, s_axi.axi_awburst, s_axi.axi_awlock,
                       s_axi.axi_awcache, s_axi.axi_awprot, s_axi.axi_awqos,
                       s_axi.axi_araddr, s_axi.axi_arsize, s_axi.axi_arburst, s_axi.axi_arlock,
                       s_axi.axi_arcache, s_axi.axi_arprot, s_axi.axi_arqos};
endmodule

// File: tb/tb_axi4_mem_slave.sv
// Directed bench for axi4_mem_slave: table of write bursts read back, plus stall and reset sequences.
module tb_axi4_mem_slave;
  localparam int MEMW = 4096;

  logic axi_aclk;
  logic axi_areset;
  int   total = 0;
  int   bad   = 0;

  logic [255:0] mdl [int];

  axi4_mem_slave_if #(.ASIZE(29), .AXI_DSIZE(256), .IDSIZE(1), .BURST_LEN_SIZE(8)) bus ();

  axi4_mem_slave #(.ASIZE(29), .AXI_DSIZE(256), .IDSIZE(1), .BURST_LEN_SIZE(8),
                   .MEM_WORDS(4096)) dut (
    .axi_aclk   (axi_aclk),
    .axi_areset (axi_areset),
    .s_axi      (bus)
  );

  initial axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  typedef struct {
    logic [28:0] addr;
    int          len;
    int          wlast_at;
    logic [31:0] seed;
    logic [31:0] strb0;
    logic        id;
    logic [1:0]  exp_resp;
  } wvec_t;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] data_of(input logic [31:0] seed, input int k);
    return {8{seed}} ^ 256'(k);
  endfunction

  // sample the chosen ready just before each rising edge; leaves us at the negedge after handshake
  task automatic wait_rdy(input int ch, output bit got);
    got = 1'b0;
    for (int n = 0; n < 64; n++) begin
      #1;
      if ((ch == 0 && bus.axi_awready) || (ch == 1 && bus.axi_wready) ||
          (ch == 2 && bus.axi_arready)) got = 1'b1;
      @(negedge axi_aclk);
      if (got) break;
    end
  endtask

  task automatic do_write(input wvec_t v, input string tag);
    int idx, nb, wi;
    bit got;
    logic [255:0] d;
    logic [31:0] s;
    idx = int'(v.addr >> 5) % MEMW;
    nb  = (v.wlast_at <= v.len) ? v.wlast_at + 1 : v.len + 1;
    bus.axi_awid = v.id; bus.axi_awaddr = v.addr; bus.axi_awlen = 8'(v.len);
    bus.axi_awvalid = 1'b1;
    wait_rdy(0, got);
    bus.axi_awvalid = 1'b0;
    check({tag, "_aw_hs"}, 256'(got), 256'(1'b1));
    for (int k = 0; k < nb; k++) begin
      d = data_of(v.seed, k);
      s = (k == 0) ? v.strb0 : 32'hFFFF_FFFF;
      bus.axi_wdata = d; bus.axi_wstrb = s; bus.axi_wlast = (k == v.wlast_at);
      bus.axi_wvalid = 1'b1;
      wait_rdy(1, got);
      if (!got) begin
        check({tag, "_w_hs"}, 256'(got), 256'(1'b1));
        break;
      end
      wi = (idx + k) % MEMW;
      if (!mdl.exists(wi)) mdl[wi] = '0;
      for (int b = 0; b < 32; b++) if (s[b]) mdl[wi][b*8 +: 8] = d[b*8 +: 8];
    end
    bus.axi_wvalid = 1'b0; bus.axi_wlast = 1'b0;
    bus.axi_bready = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 64; n++) begin
      #1;
      if (bus.axi_bvalid) begin got = 1'b1; break; end
      @(negedge axi_aclk);
    end
    check({tag, "_bvalid"}, 256'(got), 256'(1'b1));
    check({tag, "_bresp"}, 256'(bus.axi_bresp), 256'(v.exp_resp));
    check({tag, "_bid"}, 256'(bus.axi_bid), 256'(v.id));
    check({tag, "_awready_in_resp"}, 256'(bus.axi_awready), 256'(1'b0));
    @(negedge axi_aclk); #1;
    check({tag, "_bvalid_held"}, 256'(bus.axi_bvalid), 256'(1'b1));
    bus.axi_bready = 1'b1;
    @(negedge axi_aclk);
    bus.axi_bready = 1'b0;
    #1;
    check({tag, "_b_done"}, 256'({bus.axi_bvalid, bus.axi_awready}), 256'(2'b01));
    @(negedge axi_aclk);
  endtask

  task automatic do_read(input logic [28:0] addr, input int len, input logic id,
                         input bit toggle, input string tag);
    int idx, beat, cyc, i;
    bit got, stalled;
    logic [255:0] held_d;
    logic held_l;
    idx = int'(addr >> 5) % MEMW;
    bus.axi_arid = id; bus.axi_araddr = addr; bus.axi_arlen = 8'(len);
    bus.axi_arvalid = 1'b1;
    wait_rdy(2, got);
    bus.axi_arvalid = 1'b0;
    check({tag, "_ar_hs"}, 256'(got), 256'(1'b1));
    beat = 0; cyc = 0; stalled = 1'b0; held_d = '0; held_l = 1'b0;
    while (beat <= len && cyc < 200) begin
      bus.axi_rready = toggle ? (cyc % 2 == 0) : 1'b1;
      #1;
      if (bus.axi_rvalid) begin
        if (stalled) begin
          check({tag, "_hold_data"}, bus.axi_rdata, held_d);
          check({tag, "_hold_last"}, 256'(bus.axi_rlast), 256'(held_l));
        end
        if (bus.axi_rready) begin
          i = (idx + beat) % MEMW;
          if (mdl.exists(i)) check({tag, "_rdata"}, bus.axi_rdata, mdl[i]);
          check({tag, "_rlast"}, 256'(bus.axi_rlast), 256'(beat == len));
          check({tag, "_rid_rresp"}, 256'({bus.axi_rid, bus.axi_rresp}), 256'({id, 2'b00}));
          beat++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1; held_d = bus.axi_rdata; held_l = bus.axi_rlast;
        end
      end
      @(negedge axi_aclk);
      cyc++;
    end
    bus.axi_rready = 1'b0;
    check({tag, "_beats"}, 256'(beat), 256'(len + 1));
    #1;
    check({tag, "_r_idle"}, 256'({bus.axi_rvalid, bus.axi_arready}), 256'(2'b01));
    @(negedge axi_aclk);
  endtask

  function automatic logic [255:0] outs_vec();
    return 256'({bus.axi_awready, bus.axi_wready, bus.axi_bvalid, bus.axi_arready,
                 bus.axi_rvalid, bus.axi_rlast, bus.axi_bresp, bus.axi_rresp,
                 bus.axi_bid, bus.axi_rid});
  endfunction

  wvec_t tv [8];
  bit    got;

  initial begin
    //        addr          len wlast seed           strb0          id    resp
    tv[0] = '{29'h0000_0040, 7,  7,   32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 2'b00};
    tv[1] = '{29'h0000_1000, 3,  1,   32'h1111_0000, 32'hFFFF_FFFF, 1'b0, 2'b10};
    tv[2] = '{29'h0000_2000, 3,  99,  32'h2222_0000, 32'hFFFF_FFFF, 1'b1, 2'b10};
    tv[3] = '{29'h0000_3005, 0,  0,   32'h3333_0000, 32'hFFFF_FFFF, 1'b0, 2'b00};
    tv[4] = '{29'h0001_FFC0, 3,  3,   32'h4444_0000, 32'hFFFF_FFFF, 1'b1, 2'b00};
    tv[5] = '{29'h0000_0400, 0,  0,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2'b00};
    tv[6] = '{29'h0000_0400, 0,  0,   32'h1234_56AB, 32'h0000_0001, 1'b1, 2'b00};
    tv[7] = '{29'h0000_0800, 15, 15,  32'h7700_0000, 32'hFFFF_FFFF, 1'b0, 2'b00};

    axi_areset = 1'b1;
    bus.axi_awid = '0; bus.axi_awaddr = '0; bus.axi_awlen = '0; bus.axi_awsize = 3'd5;
    bus.axi_awburst = 2'b01; bus.axi_awlock = 1'b0; bus.axi_awcache = '0; bus.axi_awprot = '0;
    bus.axi_awqos = '0; bus.axi_awvalid = 1'b0;
    bus.axi_wdata = '0; bus.axi_wstrb = '0; bus.axi_wlast = 1'b0; bus.axi_wvalid = 1'b0;
    bus.axi_bready = 1'b0;
    bus.axi_arid = '0; bus.axi_araddr = '0; bus.axi_arlen = '0; bus.axi_arsize = 3'd5;
    bus.axi_arburst = 2'b01; bus.axi_arlock = 1'b0; bus.axi_arcache = '0; bus.axi_arprot = '0;
    bus.axi_arqos = '0; bus.axi_arvalid = 1'b0; bus.axi_rready = 1'b0;

    // reset state and ready release timing
    repeat (3) @(posedge axi_aclk);
    @(negedge axi_aclk); #1;
    check("reset_outputs", outs_vec(), '0);
    axi_areset = 1'b0;
    check("awready_before_release_edge", 256'(bus.axi_awready), 256'(1'b0));
    @(negedge axi_aclk); #1;
    check("readies_after_release", 256'({bus.axi_awready, bus.axi_arready}), 256'(2'b11));
    @(negedge axi_aclk);

    // table: write each burst, then read it back with rready held high
    for (int t = 0; t < 8; t++) begin
      do_write(tv[t], $sformatf("wr%0d", t));
      do_read(tv[t].addr, tv[t].len, tv[t].id, 1'b0, $sformatf("rd%0d", t));
    end

    // 16-beat read with rready alternating, stalled beats must hold
    do_read(29'h0000_0800, 15, 1'b1, 1'b1, "rd_toggle");

    // reset in the middle of an 8-beat write (during beat 2)
    bus.axi_awid = 1'b1; bus.axi_awaddr = 29'h0000_5000; bus.axi_awlen = 8'd7;
    bus.axi_awvalid = 1'b1;
    wait_rdy(0, got);
    bus.axi_awvalid = 1'b0;
    check("rst_aw_hs", 256'(got), 256'(1'b1));
    for (int k = 0; k < 2; k++) begin
      bus.axi_wdata = data_of(32'h5555_0000, k); bus.axi_wstrb = '1; bus.axi_wvalid = 1'b1;
      wait_rdy(1, got);
      check("rst_w_hs", 256'(got), 256'(1'b1));
    end
    bus.axi_wdata = data_of(32'h5555_0000, 2);
    axi_areset = 1'b1;
    bus.axi_bready = 1'b1;
    @(negedge axi_aclk);
    bus.axi_wvalid = 1'b0;
    #1;
    check("rst_mid_outputs0", outs_vec(), '0);
    @(negedge axi_aclk); #1;
    check("rst_mid_outputs1", outs_vec(), '0);
    axi_areset = 1'b0;
    check("rst_mid_awready_pre", 256'(bus.axi_awready), 256'(1'b0));
    @(negedge axi_aclk); #1;
    check("rst_mid_awready_post", 256'(bus.axi_awready), 256'(1'b1));
    for (int n = 0; n < 4; n++) begin
      check("rst_mid_no_bvalid", 256'(bus.axi_bvalid), 256'(1'b0));
      @(negedge axi_aclk); #1;
    end
    bus.axi_bready = 1'b0;
    @(negedge axi_aclk);

    // normal operation resumes after the aborted burst
    do_write('{29'h0000_6000, 1, 1, 32'h6666_0000, 32'hFFFF_FFFF, 1'b1, 2'b00}, "wr_after_rst");
    do_read(29'h0000_6000, 1, 1'b0, 1'b0, "rd_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
